// File: rtl/multicycle_ctrl_pkg.sv
// Shared definitions for the multicycle MIPS control: opcodes, funct codes,
// ALU control codes, FSM state encoding and datapath select codes.
// Pure declarations; no timing or flow control of its own.
package multicycle_ctrl_pkg;

    // Primary opcodes (Instr[31:26])
    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_J     = 6'b000010;

    // R-type funct codes (Instr[5:0])
    localparam logic [5:0] FN_ADD = 6'b100000;
    localparam logic [5:0] FN_SUB = 6'b100010;
    localparam logic [5:0] FN_AND = 6'b100100;
    localparam logic [5:0] FN_OR  = 6'b100101;
    localparam logic [5:0] FN_SLT = 6'b101010;

    // ALUControl encodings
    localparam logic [2:0] ALU_ADD = 3'b010;
    localparam logic [2:0] ALU_SUB = 3'b110;
    localparam logic [2:0] ALU_AND = 3'b000;
    localparam logic [2:0] ALU_OR  = 3'b001;
    localparam logic [2:0] ALU_SLT = 3'b111;

    // ALUSrcB selects
    localparam logic [1:0] SRCB_REGB    = 2'b00;
    localparam logic [1:0] SRCB_FOUR    = 2'b01;
    localparam logic [1:0] SRCB_IMM     = 2'b10;
    localparam logic [1:0] SRCB_IMM_SH2 = 2'b11;

    // PCSrc selects
    localparam logic [1:0] PCSRC_ALU    = 2'b00;
    localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
    localparam logic [1:0] PCSRC_JUMP   = 2'b10;

    // ALUOp from the main FSM to the ALU decoder
    typedef enum logic [1:0] {
        ALUOP_ADD   = 2'b00,
        ALUOP_SUB   = 2'b01,
        ALUOP_FUNCT = 2'b10
    } aluop_e;

    // FSM states, 4-bit encoding
    typedef enum logic [3:0] {
        S_FETCH   = 4'd0,
        S_DECODE  = 4'd1,
        S_MEMADR  = 4'd2,
        S_MEMRD   = 4'd3,
        S_MEMWB   = 4'd4,
        S_MEMWR   = 4'd5,
        S_EXECUTE = 4'd6,
        S_ALUWB   = 4'd7,
        S_BRANCH  = 4'd8,
        S_ADDIEX  = 4'd9,
        S_ADDIWB  = 4'd10,
        S_JUMP    = 4'd11
    } state_e;

    // States that wait on the memory handshake and run the wait counter
    function automatic logic is_wait_state(input state_e s);
        return (s == S_FETCH) || (s == S_MEMRD) || (s == S_MEMWR);
    endfunction

endpackage

// File: rtl/multicycle_ctrl_alu_decoder.sv
// ALU decoder: maps ALUOp (add / sub / funct) and Funct to ALUControl.
// Latency: purely combinational, zero cycles.
// Backpressure: none; flags unsupported funct codes via funct_illegal.
// Ports: ALUOp (operation class), Funct (Instr[5:0]),
//        ALUControl (ALU function), funct_illegal (unsupported R-type funct).
module alu_decoder
    import multicycle_ctrl_pkg::*;
(
    input  aluop_e     ALUOp,
    input  logic [5:0] Funct,
    output logic [2:0] ALUControl,
    output logic       funct_illegal
);

    always_comb begin
        ALUControl    = ALU_ADD;
        funct_illegal = 1'b0;
        case (ALUOp)
            ALUOP_ADD: ALUControl = ALU_ADD;
            ALUOP_SUB: ALUControl = ALU_SUB;
            ALUOP_FUNCT: begin
                case (Funct)
                    FN_ADD:  ALUControl = ALU_ADD;
                    FN_SUB:  ALUControl = ALU_SUB;
                    FN_AND:  ALUControl = ALU_AND;
                    FN_OR:   ALUControl = ALU_OR;
                    FN_SLT:  ALUControl = ALU_SLT;
                    default: begin
                        // Unsupported funct falls back to add so the ALU
                        // output stays benign while the FSM aborts.
                        ALUControl    = ALU_ADD;
                        funct_illegal = 1'b1;
                    end
                endcase
            end
            default: ALUControl = ALU_ADD;
        endcase
    end

endmodule

// File: rtl/multicycle_ctrl.sv
// Multicycle MIPS control FSM sequencing a shared ALU and unified memory port.
// Latency (mem_ready high): R=4, lw=5, sw=4, beq=3, addi=4, j=3 cycles.
// Backpressure: FETCH/MEMRD/MEMWR stall on mem_ready; WAIT_LIMIT aborts stuck waits.
// Ports: clk, rst (async active-low); Op/Funct from the IR; Zero from the ALU;
//        mem_ready handshake; datapath enables/selects, ALUControl; status
//        pulses InstrDone, IllegalOp, MemTimeout.
module multicycle_ctrl
    import multicycle_ctrl_pkg::*;
#(
    parameter int WAIT_LIMIT = 255,
    parameter int CNT_W      = 8
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [5:0] Op,
    input  logic [5:0] Funct,
    input  logic       Zero,
    input  logic       mem_ready,
    output logic       IorD,
    output logic       MemWrite,
    output logic       IRWrite,
    output logic       PCEn,
    output logic [1:0] PCSrc,
    output logic       ALUSrcA,
    output logic [1:0] ALUSrcB,
    output logic [2:0] ALUControl,
    output logic       RegDst,
    output logic       MemtoReg,
    output logic       RegWrite,
    output logic       InstrDone,
    output logic       IllegalOp,
    output logic       MemTimeout
);

    localparam logic [CNT_W-1:0] LIMIT      = CNT_W'(WAIT_LIMIT);
    localparam bit               TIMEOUT_EN = (WAIT_LIMIT != 0);

    state_e           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    aluop_e     alu_op;
    logic       funct_illegal;
    logic       in_wait;
    logic       timeout;

    // Raw (ungated) control terms produced by the state decode
    logic       iord_c, mem_write_c, ir_write_c, pc_write_c, branch_c;
    logic [1:0] pc_src_c, src_b_c;
    logic       src_a_c, reg_dst_c, mem_to_reg_c, reg_write_c;
    logic       done_c, illegal_c, timeout_c;

    alu_decoder u_alu_decoder (
        .ALUOp         (alu_op),
        .Funct         (Funct),
        .ALUControl    (ALUControl),
        .funct_illegal (funct_illegal)
    );

    assign in_wait = is_wait_state(state_q);
    // mem_ready in the limit cycle wins over the abort
    assign timeout = TIMEOUT_EN && in_wait && !mem_ready && (cnt_q == LIMIT);

    always_comb begin
        state_d      = state_q;
        alu_op       = ALUOP_ADD;
        iord_c       = 1'b0;
        mem_write_c  = 1'b0;
        ir_write_c   = 1'b0;
        pc_write_c   = 1'b0;
        branch_c     = 1'b0;
        pc_src_c     = PCSRC_ALU;
        src_a_c      = 1'b0;
        src_b_c      = SRCB_FOUR;
        reg_dst_c    = 1'b0;
        mem_to_reg_c = 1'b0;
        reg_write_c  = 1'b0;
        done_c       = 1'b0;
        illegal_c    = 1'b0;
        timeout_c    = 1'b0;

        case (state_q)
            S_FETCH: begin
                if (timeout) begin
                    // Retry the fetch; the PC is left untouched
                    timeout_c = 1'b1;
                    state_d   = S_FETCH;
                end else if (mem_ready) begin
                    ir_write_c = 1'b1;
                    pc_write_c = 1'b1;
                    state_d    = S_DECODE;
                end
            end
            S_DECODE: begin
                // ALU precomputes PC+4 + (SignImm<<2) for a possible branch
                src_b_c = SRCB_IMM_SH2;
                case (Op)
                    OP_LW, OP_SW: state_d = S_MEMADR;
                    OP_RTYPE:     state_d = S_EXECUTE;
                    OP_BEQ:       state_d = S_BRANCH;
                    OP_ADDI:      state_d = S_ADDIEX;
                    OP_J:         state_d = S_JUMP;
                    default: begin
                        illegal_c = 1'b1;
                        state_d   = S_FETCH;
                    end
                endcase
            end
            S_MEMADR: begin
                src_a_c = 1'b1;
                src_b_c = SRCB_IMM;
                if (Op == OP_SW)      state_d = S_MEMWR;
                else if (Op == OP_LW) state_d = S_MEMRD;
                else                  state_d = S_FETCH;
            end
            S_MEMRD: begin
                iord_c = 1'b1;
                if (timeout) begin
                    timeout_c = 1'b1;
                    state_d   = S_FETCH;
                end else if (mem_ready) begin
                    state_d = S_MEMWB;
                end
            end
            S_MEMWB: begin
                mem_to_reg_c = 1'b1;
                reg_write_c  = 1'b1;
                done_c       = 1'b1;
                state_d      = S_FETCH;
            end
            S_MEMWR: begin
                iord_c = 1'b1;
                if (timeout) begin
                    // Strobe dropped in the abort cycle
                    timeout_c = 1'b1;
                    state_d   = S_FETCH;
                end else begin
                    mem_write_c = 1'b1;
                    if (mem_ready) begin
                        done_c  = 1'b1;
                        state_d = S_FETCH;
                    end
                end
            end
            S_EXECUTE: begin
                src_a_c = 1'b1;
                src_b_c = SRCB_REGB;
                alu_op  = ALUOP_FUNCT;
                if (funct_illegal) begin
                    illegal_c = 1'b1;
                    state_d   = S_FETCH;
                end else begin
                    state_d = S_ALUWB;
                end
            end
            S_ALUWB: begin
                reg_dst_c   = 1'b1;
                reg_write_c = 1'b1;
                done_c      = 1'b1;
                state_d     = S_FETCH;
            end
            S_BRANCH: begin
                src_a_c  = 1'b1;
                src_b_c  = SRCB_REGB;
                alu_op   = ALUOP_SUB;
                pc_src_c = PCSRC_ALUOUT;
                branch_c = 1'b1;
                done_c   = 1'b1;
                state_d  = S_FETCH;
            end
            S_ADDIEX: begin
                src_a_c = 1'b1;
                src_b_c = SRCB_IMM;
                state_d = S_ADDIWB;
            end
            S_ADDIWB: begin
                reg_write_c = 1'b1;
                done_c      = 1'b1;
                state_d     = S_FETCH;
            end
            S_JUMP: begin
                pc_src_c   = PCSRC_JUMP;
                pc_write_c = 1'b1;
                done_c     = 1'b1;
                state_d    = S_FETCH;
            end
            default: state_d = S_FETCH;
        endcase
    end

    // Counter restarts on every state entry (and after an abort, which may
    // loop FETCH back onto itself); it only counts unready wait cycles.
    always_comb begin
        cnt_d = cnt_q;
        if (timeout || (state_d != state_q)) begin
            cnt_d = '0;
        end else if (in_wait && !mem_ready) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= S_FETCH;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // Enables and pulses are forced low while reset is held: FETCH would
    // otherwise raise IRWrite/PCEn from mem_ready alone. Selects are already
    // at their FETCH values because the state register is in FETCH.
    assign IorD       = iord_c;
    assign PCSrc      = pc_src_c;
    assign ALUSrcA    = src_a_c;
    assign ALUSrcB    = src_b_c;
    assign RegDst     = reg_dst_c;
    assign MemtoReg   = mem_to_reg_c;
    assign MemWrite   = rst & mem_write_c;
    assign IRWrite    = rst & ir_write_c;
    assign PCEn       = rst & (pc_write_c | (branch_c & Zero));
    assign RegWrite   = rst & reg_write_c;
    assign InstrDone  = rst & done_c;
    assign IllegalOp  = rst & illegal_c;
    assign MemTimeout = rst & timeout_c;

endmodule

// File: tb/tb_multicycle_ctrl.sv
module tb_multicycle_ctrl;

    typedef struct packed {
        logic       iord;
        logic       mem_write;
        logic       ir_write;
        logic       pc_en;
        logic [1:0] pc_src;
        logic       alu_src_a;
        logic [1:0] alu_src_b;
        logic [2:0] alu_ctl;
        logic       reg_dst;
        logic       mem_to_reg;
        logic       reg_write;
        logic       instr_done;
        logic       illegal_op;
        logic       mem_timeout;
    } ov_t;

    typedef struct packed {
        ov_t val;
        ov_t care;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [5:0] Op, Funct;
    logic       Zero, mem_ready;
    logic       IorD, MemWrite, IRWrite, PCEn, ALUSrcA, RegDst, MemtoReg;
    logic       RegWrite, InstrDone, IllegalOp, MemTimeout;
    logic [1:0] PCSrc, ALUSrcB;
    logic [2:0] ALUControl;

    int n_asserts = 0;
    int n_fail    = 0;

    exp_t  sb_q[$];
    string tag_q[$];

    ov_t obs;
    assign obs = {IorD, MemWrite, IRWrite, PCEn, PCSrc, ALUSrcA, ALUSrcB,
                  ALUControl, RegDst, MemtoReg, RegWrite, InstrDone,
                  IllegalOp, MemTimeout};

    always #5 clk = ~clk;

    multicycle_ctrl #(.WAIT_LIMIT(4), .CNT_W(8)) dut (
        .clk        (clk),
        .rst        (rst_n),
        .Op         (Op),
        .Funct      (Funct),
        .Zero       (Zero),
        .mem_ready  (mem_ready),
        .IorD       (IorD),
        .MemWrite   (MemWrite),
        .IRWrite    (IRWrite),
        .PCEn       (PCEn),
        .PCSrc      (PCSrc),
        .ALUSrcA    (ALUSrcA),
        .ALUSrcB    (ALUSrcB),
        .ALUControl (ALUControl),
        .RegDst     (RegDst),
        .MemtoReg   (MemtoReg),
        .RegWrite   (RegWrite),
        .InstrDone  (InstrDone),
        .IllegalOp  (IllegalOp),
        .MemTimeout (MemTimeout)
    );

    // ---------------- expected-value builders ----------------
    // Enables and pulses are always checked (0 unless stated); selects only
    // where the state defines them.
    function automatic exp_t base();
        exp_t e;
        e.val  = '0;
        e.care = '0;
        e.care.mem_write   = 1'b1;
        e.care.ir_write    = 1'b1;
        e.care.pc_en       = 1'b1;
        e.care.reg_write   = 1'b1;
        e.care.instr_done  = 1'b1;
        e.care.illegal_op  = 1'b1;
        e.care.mem_timeout = 1'b1;
        return e;
    endfunction

    function automatic exp_t e_fetch(input logic rdy, input logic to);
        exp_t e = base();
        e.care.iord = 1'b1; e.care.alu_src_a = 1'b1; e.care.alu_src_b = 2'b11;
        e.care.alu_ctl = 3'b111; e.care.pc_src = 2'b11;
        e.val.alu_src_b   = 2'b01;
        e.val.alu_ctl     = 3'b010;
        e.val.ir_write    = rdy & ~to;
        e.val.pc_en       = rdy & ~to;
        e.val.mem_timeout = to;
        return e;
    endfunction

    function automatic exp_t e_decode(input logic ill);
        exp_t e = base();
        e.care.alu_src_a = 1'b1; e.care.alu_src_b = 2'b11; e.care.alu_ctl = 3'b111;
        e.val.alu_src_b  = 2'b11;
        e.val.alu_ctl    = 3'b010;
        e.val.illegal_op = ill;
        return e;
    endfunction

    function automatic exp_t e_alu(input logic [1:0] srcb, input logic [2:0] ctl,
                                   input logic ill);
        exp_t e = base();
        e.care.alu_src_a = 1'b1; e.care.alu_src_b = 2'b11; e.care.alu_ctl = 3'b111;
        e.val.alu_src_a  = 1'b1;
        e.val.alu_src_b  = srcb;
        e.val.alu_ctl    = ctl;
        e.val.illegal_op = ill;
        return e;
    endfunction

    function automatic exp_t e_wb(input logic dst, input logic m2r);
        exp_t e = base();
        e.care.reg_dst = 1'b1; e.care.mem_to_reg = 1'b1;
        e.val.reg_dst    = dst;
        e.val.mem_to_reg = m2r;
        e.val.reg_write  = 1'b1;
        e.val.instr_done = 1'b1;
        return e;
    endfunction

    function automatic exp_t e_memrd();
        exp_t e = base();
        e.care.iord = 1'b1;
        e.val.iord  = 1'b1;
        return e;
    endfunction

    function automatic exp_t e_memwr(input logic rdy, input logic to);
        exp_t e = base();
        e.care.iord = 1'b1;
        e.val.iord        = 1'b1;
        e.val.mem_write   = ~to;
        e.val.instr_done  = rdy & ~to;
        e.val.mem_timeout = to;
        return e;
    endfunction

    function automatic exp_t e_branch(input logic z);
        exp_t e = e_alu(2'b00, 3'b110, 1'b0);
        e.care.pc_src   = 2'b11;
        e.val.pc_src     = 2'b01;
        e.val.pc_en      = z;
        e.val.instr_done = 1'b1;
        return e;
    endfunction

    function automatic exp_t e_jump();
        exp_t e = base();
        e.care.pc_src = 2'b11;
        e.val.pc_src     = 2'b10;
        e.val.pc_en      = 1'b1;
        e.val.instr_done = 1'b1;
        return e;
    endfunction

    // ---------------- scoreboard ----------------
    task automatic check_front();
        exp_t  e;
        string t;
        logic [17:0] o, v, c;
        if (sb_q.size() == 0) begin
            n_asserts++;
            n_fail++;
            $error("FAIL scoreboard_empty observed=%h required=entry", obs);
            return;
        end
        e = sb_q.pop_front();
        t = tag_q.pop_front();
        o = obs;
        v = e.val;
        c = e.care;
        n_asserts++;
        assert ((o & c) === (v & c))
        else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h care=%h", t, o & c, v & c, c);
        end
    endtask

    task automatic chk_bit(input string t, input logic o, input logic x);
        n_asserts++;
        assert (o === x)
        else begin
            n_fail++;
            $error("FAIL %s observed=%b expected=%b", t, o, x);
        end
    endtask

    // Entered just after a rising edge; drives inputs, checks at the falling
    // edge, returns just after the next rising edge.
    task automatic step(input logic rdy, input logic z, input exp_t e, input string t);
        mem_ready = rdy;
        Zero      = z;
        sb_q.push_back(e);
        tag_q.push_back(t);
        @(negedge clk);
        check_front();
        @(posedge clk);
        #1;
    endtask

    task automatic set_instr(input logic [5:0] op, input logic [5:0] fn);
        Op    = op;
        Funct = fn;
    endtask

    logic [5:0] fn_tab  [5] = '{6'b100000, 6'b100010, 6'b100100, 6'b100101, 6'b101010};
    logic [2:0] ctl_tab [5] = '{3'b010,    3'b110,    3'b000,    3'b001,    3'b111};

    initial begin
        rst_n = 1'b0; Op = '0; Funct = '0; Zero = 1'b0; mem_ready = 1'b1;
        @(posedge clk); #1;
        // Reset held with mem_ready high: FETCH selects, no enables
        step(1'b1, 1'b0, e_fetch(1'b0, 1'b0), "reset_hold");
        rst_n = 1'b1;

        // R-type, each supported funct, 4 cycles
        for (int i = 0; i < 5; i++) begin
            set_instr(6'b000000, fn_tab[i]);
            step(1'b1, 1'b0, e_fetch(1'b1, 1'b0), "r_fetch");
            step(1'b1, 1'b0, e_decode(1'b0), "r_decode");
            step(1'b1, 1'b0, e_alu(2'b00, ctl_tab[i], 1'b0), "r_execute");
            step(1'b1, 1'b0, e_wb(1'b1, 1'b0), "r_aluwb");
        end

        // lw with three wait cycles in MEMRD: 8 cycles total
        set_instr(6'b100011, 6'b000000);
        step(1'b1, 1'b0, e_fetch(1'b1, 1'b0), "lw_fetch");
        step(1'b1, 1'b0, e_decode(1'b0), "lw_decode");
        step(1'b1, 1'b0, e_alu(2'b10, 3'b010, 1'b0), "lw_memadr");
        for (int i = 0; i < 3; i++) step(1'b0, 1'b0, e_memrd(), "lw_memrd_wait");
        step(1'b1, 1'b0, e_memrd(), "lw_memrd_ready");
        step(1'b1, 1'b0, e_wb(1'b0, 1'b1), "lw_memwb");

        // sw, no waits
        set_instr(6'b101011, 6'b000000);
        step(1'b1, 1'b0, e_fetch(1'b1, 1'b0), "sw_fetch");
        step(1'b1, 1'b0, e_decode(1'b0), "sw_decode");
        step(1'b1, 1'b0, e_alu(2'b10, 3'b010, 1'b0), "sw_memadr");
        step(1'b1, 1'b0, e_memwr(1'b1, 1'b0), "sw_memwr");

        // beq taken and not taken
        for (int z = 1; z >= 0; z--) begin
            set_instr(6'b000100, 6'b000000);
            step(1'b1, 1'(z), e_fetch(1'b1, 1'b0), "beq_fetch");
            step(1'b1, 1'(z), e_decode(1'b0), "beq_decode");
            step(1'b1, 1'(z), e_branch(1'(z)), "beq_branch");
        end

        // Illegal opcode, then addi (its fetch proves the return to FETCH)
        set_instr(6'b111111, 6'b000000);
        step(1'b1, 1'b0, e_fetch(1'b1, 1'b0), "ill_fetch");
        step(1'b1, 1'b0, e_decode(1'b1), "ill_op_decode");
        set_instr(6'b001000, 6'b000000);
        step(1'b1, 1'b0, e_fetch(1'b1, 1'b0), "addi_fetch");
        step(1'b1, 1'b0, e_decode(1'b0), "addi_decode");
        step(1'b1, 1'b0, e_alu(2'b10, 3'b010, 1'b0), "addi_ex");
        step(1'b1, 1'b0, e_wb(1'b0, 1'b0), "addi_wb");

        // Illegal funct: abort in EXECUTE with no ALUWB
        set_instr(6'b000000, 6'b000111);
        step(1'b1, 1'b0, e_fetch(1'b1, 1'b0), "illfn_fetch");
        step(1'b1, 1'b0, e_decode(1'b0), "illfn_decode");
        step(1'b1, 1'b0, e_alu(2'b00, 3'b010, 1'b1), "illfn_execute");
        step(1'b0, 1'b0, e_fetch(1'b0, 1'b0), "illfn_back_fetch");

        // Fetch timeout then a jump
        set_instr(6'b000010, 6'b000000);
        for (int i = 0; i < 3; i++) step(1'b0, 1'b0, e_fetch(1'b0, 1'b0), "fto_wait");
        step(1'b0, 1'b0, e_fetch(1'b0, 1'b1), "fto_timeout");
        step(1'b1, 1'b0, e_fetch(1'b1, 1'b0), "j_fetch");
        step(1'b1, 1'b0, e_decode(1'b0), "j_decode");
        step(1'b1, 1'b0, e_jump(), "j_jump");

        // sw timeout: 4 strobe cycles then abort
        set_instr(6'b101011, 6'b000000);
        step(1'b1, 1'b0, e_fetch(1'b1, 1'b0), "swto_fetch");
        step(1'b1, 1'b0, e_decode(1'b0), "swto_decode");
        step(1'b1, 1'b0, e_alu(2'b10, 3'b010, 1'b0), "swto_memadr");
        for (int i = 0; i < 4; i++) step(1'b0, 1'b0, e_memwr(1'b0, 1'b0), "swto_wait");
        step(1'b0, 1'b0, e_memwr(1'b0, 1'b1), "swto_timeout");
        step(1'b1, 1'b0, e_fetch(1'b1, 1'b0), "swlim_fetch");

        // sw with mem_ready arriving exactly at the limit
        step(1'b1, 1'b0, e_decode(1'b0), "swlim_decode");
        step(1'b1, 1'b0, e_alu(2'b10, 3'b010, 1'b0), "swlim_memadr");
        for (int i = 0; i < 4; i++) step(1'b0, 1'b0, e_memwr(1'b0, 1'b0), "swlim_wait");
        step(1'b1, 1'b0, e_memwr(1'b1, 1'b0), "swlim_done");

        // Reset during MEMWR
        step(1'b1, 1'b0, e_fetch(1'b1, 1'b0), "swrst_fetch");
        step(1'b1, 1'b0, e_decode(1'b0), "swrst_decode");
        step(1'b1, 1'b0, e_alu(2'b10, 3'b010, 1'b0), "swrst_memadr");
        step(1'b0, 1'b0, e_memwr(1'b0, 1'b0), "swrst_memwr");
        #2;
        chk_bit("swrst_memwrite_before", MemWrite, 1'b1);
        rst_n = 1'b0;
        #1;
        chk_bit("swrst_memwrite_async", MemWrite, 1'b0);
        step(1'b1, 1'b0, e_fetch(1'b0, 1'b0), "swrst_held");
        rst_n = 1'b1;
        step(1'b0, 1'b0, e_fetch(1'b0, 1'b0), "swrst_post_fetch");
        step(1'b1, 1'b0, e_fetch(1'b1, 1'b0), "swrst_refetch");
        step(1'b1, 1'b0, e_decode(1'b0), "swrst_redecode");

        $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
        $finish;
    end

endmodule

// File: doc/multicycle_ctrl.md
Name: multicycle_ctrl

Overview:
- Moore-style FSM that sequences the shared multicycle MIPS datapath: one ALU and one unified instruction/data memory port, reused across cycles.
- Drives all register enables, mux selects and ALUControl from Op/Funct/Zero.
- Waits on a memory ready handshake in every memory-access state.
- Sits between the instruction register and the datapath; replaces the combinational control unit for the multicycle build.

Parameters:
- WAIT_LIMIT, 255: maximum cycles spent waiting on mem_ready in one memory state before abort; 0 disables the timeout.
- CNT_W, 8: width of the wait counter; must hold WAIT_LIMIT.

Ports:
- clk  in  1  system clock, rising edge
- rst  in  1  asynchronous, active-low reset
- Op  in  6  Instr[31:26] from the instruction register
- Funct  in  6  Instr[5:0]
- Zero  in  1  ALU zero flag
- mem_ready  in  1  memory has completed the current read or write this cycle
- IorD  out  1  memory address select: 0 = PC, 1 = ALUOut
- MemWrite  out  1  memory write strobe
- IRWrite  out  1  instruction register load enable
- PCEn  out  1  PC load enable, equal to PCWrite | (Branch & Zero)
- PCSrc  out  2  next PC select: 00 = ALU, 01 = ALUOut, 10 = jump target
- ALUSrcA  out  1  ALU A select: 0 = PC, 1 = register A
- ALUSrcB  out  2  ALU B select: 00 = register B, 01 = 4, 10 = SignImm, 11 = SignImm<<2
- ALUControl  out  3  ALU function: 010 add, 110 sub, 000 and, 001 or, 111 slt
- RegDst  out  1  destination select: 0 = rt, 1 = rd
- MemtoReg  out  1  writeback select: 0 = ALUOut, 1 = memory data
- RegWrite  out  1  register file write enable
- InstrDone  out  1  one-cycle pulse on the last cycle of each completed instruction
- IllegalOp  out  1  one-cycle pulse on an unsupported opcode or funct
- MemTimeout  out  1  one-cycle pulse when a memory wait is aborted

Behaviour:
- Reset (rst=0, asynchronous):
  - state=FETCH, wait counter=0.
  - While reset is held, all enables and pulses (MemWrite, IRWrite, PCEn, RegWrite, InstrDone, IllegalOp, MemTimeout) are 0.
  - Selects take their FETCH values: IorD=0, ALUSrcA=0, ALUSrcB=01, ALUControl=010, PCSrc=00.
- Outputs decode from the state register only, except for the mem_ready gating and the Zero term noted below.
- Opcodes: R=000000, lw=100011, sw=101011, beq=000100, addi=001000, j=000010.
- Funct decode (R-type): 100000 add, 100010 sub, 100100 and, 100101 or, 101010 slt.
- FETCH:
  - IorD=0, ALUSrcA=0, ALUSrcB=01, add.
  - If mem_ready: IRWrite=1, PCEn=1, next state DECODE.
  - Otherwise stay in FETCH with no writes.
- DECODE:
  - ALUSrcA=0, ALUSrcB=11, add (precomputes the branch target).
  - Next state: lw/sw -> MEMADR, R -> EXECUTE, beq -> BRANCH, addi -> ADDIEX, j -> JUMP.
  - Any other opcode: IllegalOp=1, InstrDone=0, next state FETCH.
- MEMADR: ALUSrcA=1, ALUSrcB=10, add. Next state MEMRD for lw, MEMWR for sw.
- MEMRD: IorD=1. On mem_ready go to MEMWB; otherwise stay.
- MEMWB: RegDst=0, MemtoReg=1, RegWrite=1, InstrDone=1, next state FETCH.
- MEMWR:
  - IorD=1, MemWrite=1 held every cycle until mem_ready.
  - On mem_ready: InstrDone=1, next state FETCH.
- EXECUTE:
  - ALUSrcA=1, ALUSrcB=00, ALUControl from Funct, next state ALUWB.
  - Unsupported funct: ALUControl=010, IllegalOp=1, next state FETCH (no writeback).
- ALUWB: RegDst=1, MemtoReg=0, RegWrite=1, InstrDone=1, next state FETCH.
- BRANCH: ALUSrcA=1, ALUSrcB=00, sub, PCSrc=01, PCEn=Zero, InstrDone=1, next state FETCH.
- ADDIEX: ALUSrcA=1, ALUSrcB=10, add, next state ADDIWB.
- ADDIWB: RegDst=0, MemtoReg=0, RegWrite=1, InstrDone=1, next state FETCH.
- JUMP: PCSrc=10, PCEn=1, InstrDone=1, next state FETCH.
- Latency with mem_ready tied high: R=4, lw=5, sw=4, beq=3, addi=4, j=3 cycles. Each wait cycle adds 1.
- Wait counter:
  - Cleared on entry to FETCH, MEMRD or MEMWR.
  - Increments on each cycle in those states with mem_ready=0.
  - If WAIT_LIMIT != 0, count==WAIT_LIMIT and mem_ready=0: MemTimeout=1, all writes suppressed that cycle, next state FETCH.
  - A timeout in FETCH retries the fetch; the PC is unchanged.
  - mem_ready=1 in the same cycle as the limit: mem_ready wins and no timeout is raised.
- Reset asserted mid-instruction: immediate return to FETCH; the partial instruction has no further effect.
- Op/Funct are stable from the IR after FETCH. The FSM does not latch them.

Decomposition:
- Shared package holds:
  - opcode and funct localparams
  - ALUControl codes
  - state encoding (4-bit, 12 states)
  - ALUSrcB/PCSrc select codes
- One sub-module, alu_decoder: combinational. Inputs: ALUOp (2 bits: add, sub, funct) and Funct. Outputs: ALUControl and funct_illegal. Reused by the single-cycle control unit.

Test Plan:
- Reset release, mem_ready=1, Op=000000, Funct=100000 -> states FETCH, DECODE, EXECUTE, ALUWB. RegWrite=1 and RegDst=1 in cycle 4. InstrDone pulses in cycle 4.
- lw with mem_ready low for 3 cycles in MEMRD -> MEMRD held 4 cycles with IorD=1 and RegWrite=0. MEMWB follows with MemtoReg=1, RegWrite=1. Total 8 cycles.
- beq with Zero=1 -> PCEn=1, PCSrc=01 in cycle 3. Repeat with Zero=0 -> PCEn=0 and InstrDone=1 in both cases.
- Op=111111 -> IllegalOp pulse in DECODE, next state FETCH, no RegWrite/MemWrite. Op=0 with Funct=000111 -> IllegalOp in EXECUTE, no ALUWB.
- WAIT_LIMIT=4, sw with mem_ready held 0 -> MemWrite high for 4 cycles, MemTimeout pulse in the 5th, then FETCH. mem_ready=1 exactly at the limit -> no timeout, InstrDone=1.
- rst driven low during MEMWR with MemWrite=1 -> MemWrite falls asynchronously. After release: FETCH, all pulses 0.
